// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the sprite draw engine.
package sprite_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int SPRITE_W_DEF = 8;
  localparam int SPRITE_H_DEF = 8;

  localparam int BG_AW  = 15;
  localparam int SPR_AW = 6;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int COL_W  = 3;

  localparam logic [COL_W-1:0] TRANSPARENT = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BG_RUN   = 3'd1,
    BG_FLUSH = 3'd2,
    BG_DONE  = 3'd3,
    CH_RUN   = 3'd4,
    CH_FLUSH = 3'd5,
    CH_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/tile_scan_counter.sv
// Raster scan of one tile: i walks across a row, j steps down on each row wrap.
module tile_scan_counter #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int I_W = $clog2(SPRITE_W),
  parameter int J_W = $clog2(SPRITE_H)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  output logic [I_W-1:0] i,
  output logic [J_W-1:0] j,
  output logic           last
);

  logic i_wrap;
  logic j_wrap;

  assign i_wrap = (i == I_W'(SPRITE_W - 1));
  assign j_wrap = (j == J_W'(SPRITE_H - 1));
  assign last   = i_wrap && j_wrap;

  // Wrapping after the last pixel leaves the counters at 0 for the next frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      i <= '0;
      j <= '0;
    end else if (enable) begin
      if (i_wrap) begin
        i <= '0;
        j <= j_wrap ? '0 : j + J_W'(1);
      end else begin
        i <= i + I_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_engine.sv
// Streams one background or sprite tile to the VGA adapter per request.
// Build option: define SPRITE_TRANSPARENCY_EN to skip TRANSPARENT sprite pixels.
module sprite_draw_engine
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              drawBG,
  input  logic              drawChar,
  input  logic [X_W-1:0]    xIn,
  input  logic [Y_W-1:0]    yIn,
  output logic              doneBG,
  output logic              doneChar,
  output logic              busy,
  output logic [BG_AW-1:0]  bg_addr,
  input  logic [COL_W-1:0]  bg_data,
  output logic [SPR_AW-1:0] spr_addr,
  input  logic [COL_W-1:0]  spr_data,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [COL_W-1:0]  vga_colour,
  output logic              vga_plot
);

  localparam int I_W = $clog2(SPRITE_W);
  localparam int J_W = $clog2(SPRITE_H);

  state_t         state;
  logic           pending;
  logic           flush_cnt;
  logic [X_W-1:0] x_lat;
  logic [Y_W-1:0] y_lat;

  logic [I_W-1:0] i;
  logic [J_W-1:0] j;
  logic           last;
  logic           running;
  logic           char_run;
  logic [X_W:0]   px;
  logic [Y_W:0]   py;
  logic           in_bounds;

  logic           s1_valid;
  logic           s1_char;
  logic           s1_inb;
  logic [X_W-1:0] s1_x;
  logic [Y_W-1:0] s1_y;
  logic           plot_ok;

  assign running  = (state == BG_RUN) || (state == CH_RUN);
  assign char_run = (state == CH_RUN);

  tile_scan_counter #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H)
  ) u_scan (
    .clock (clock),
    .reset (reset),
    .enable(running),
    .i     (i),
    .j     (j),
    .last  (last)
  );

  // One extra bit on each sum so a tile hanging off the edge is clipped, never wrapped.
  assign px        = {1'b0, x_lat} + (X_W + 1)'(i);
  assign py        = {1'b0, y_lat} + (Y_W + 1)'(j);
  assign in_bounds = (px < (X_W + 1)'(SCREEN_W)) && (py < (Y_W + 1)'(SCREEN_H));

  assign bg_addr  = (running && !char_run && in_bounds)
                  ? BG_AW'(py) * BG_AW'(SCREEN_W) + BG_AW'(px) : '0;
  assign spr_addr = char_run ? SPR_AW'(j) * SPR_AW'(SPRITE_W) + SPR_AW'(i) : '0;

`ifdef SPRITE_TRANSPARENCY_EN
  assign plot_ok = s1_valid && s1_inb && !(s1_char && (spr_data == TRANSPARENT));
`else
  assign plot_ok = s1_valid && s1_inb;
`endif

  // Control: a pending sprite draw relaunches from IDLE so it times exactly like a fresh request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      flush_cnt <= 1'b0;
      busy      <= 1'b0;
      doneBG    <= 1'b0;
      doneChar  <= 1'b0;
      x_lat     <= '0;
      y_lat     <= '0;
    end else begin
      doneBG   <= 1'b0;
      doneChar <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= CH_RUN;
          end else if (drawBG) begin
            x_lat   <= xIn;
            y_lat   <= yIn;
            pending <= drawChar;
            busy    <= 1'b1;
            state   <= BG_RUN;
          end else if (drawChar) begin
            x_lat <= xIn;
            y_lat <= yIn;
            busy  <= 1'b1;
            state <= CH_RUN;
          end
        end
        BG_RUN: begin
          if (last) begin
            flush_cnt <= 1'b0;
            state     <= BG_FLUSH;
          end
        end
        BG_FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            doneBG <= 1'b1;
            state  <= BG_DONE;
          end
        end
        BG_DONE: begin
          busy  <= pending;
          state <= IDLE;
        end
        CH_RUN: begin
          if (last) begin
            flush_cnt <= 1'b0;
            state     <= CH_FLUSH;
          end
        end
        CH_FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            doneChar <= 1'b1;
            state    <= CH_DONE;
          end
        end
        CH_DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage pixel pipeline: coordinates travel alongside the one-cycle ROM read.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_char    <= 1'b0;
      s1_inb     <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      s1_valid <= running;
      s1_char  <= char_run;
      s1_inb   <= in_bounds;
      s1_x     <= px[X_W-1:0];
      s1_y     <= py[Y_W-1:0];
      vga_plot <= plot_ok;
      if (s1_valid) begin
        vga_x <= s1_x;
        vga_y <= s1_y;
      end
      if (plot_ok) begin
        vga_colour <= s1_char ? spr_data : bg_data;
      end
    end
  end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Responder side of the sprite movement handshake: accepts drawBG / drawChar pulses plus the sprite's X/Y from the movement FSM.
- Streams one SPRITE_W x SPRITE_H tile of pixels to the VGA adapter, then returns a one-cycle doneBG / doneChar.
- drawBG restores the background under the footprint from the background ROM. drawChar paints the sprite from the sprite ROM.
- Sits between the movement FSM and the vga_adapter / ROM instances.

Parameters:
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.
- SPRITE_W, 8, tile width in pixels.
- SPRITE_H, 8, tile height in pixels.
- TRANSPARENT, 3'b101, sprite colour that is never plotted (see Optional Feature).

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- drawBG  in  1  one-cycle request: redraw background at (xIn, yIn).
- drawChar  in  1  one-cycle request: draw sprite at (xIn, yIn).
- xIn  in  8  tile top-left X; sampled on the accepted request cycle.
- yIn  in  7  tile top-left Y; sampled on the accepted request cycle.
- doneBG  out  1  one-cycle pulse: background redraw complete.
- doneChar  out  1  one-cycle pulse: sprite draw complete.
- busy  out  1  high from the cycle after acceptance through the done pulse.
- bg_addr  out  15  background ROM address = y*SCREEN_W + x.
- bg_data  in  3  background ROM data; valid one cycle after bg_addr.
- spr_addr  out  6  sprite ROM address = j*SPRITE_W + i.
- spr_data  in  3  sprite ROM data; valid one cycle after spr_addr.
- vga_x  out  8  plot X.
- vga_y  out  7  plot Y.
- vga_colour  out  3  plot colour.
- vga_plot  out  1  write strobe to the VGA adapter.

Behaviour:
- Reset: state IDLE, counters i=j=0, pending=0. All outputs 0: busy, doneBG, doneChar, vga_plot, vga_x, vga_y, vga_colour, bg_addr, spr_addr.
- Reset applied mid-operation aborts the frame. No done pulse. vga_plot is 0 from the next cycle.
- States: IDLE, BG_RUN, BG_FLUSH, BG_DONE, CH_RUN, CH_FLUSH, CH_DONE.
- IDLE:
  - drawBG=1 latches xIn/yIn and goes to BG_RUN.
  - else drawChar=1 latches and goes to CH_RUN.
- Simultaneous drawBG and drawChar in IDLE: BG is served first; pending is set.
  - After BG_DONE, go to CH_RUN using the same latched coordinates.
  - This yields doneBG, then doneChar.
- Requests arriving while busy are ignored and not queued.
- RUN (request accepted at cycle 0):
  - Pixel k = j*SPRITE_W + i is addressed in cycle 1+k.
  - Address is combinational from the counters. i increments and wraps to 0 at SPRITE_W-1; j increments on that wrap.
  - Leave RUN after k = SPRITE_W*SPRITE_H-1.
- Pipeline: ROM data arrives at cycle 2+k. Registered VGA outputs are valid at cycle 3+k.
  - vga_x = X+i, vga_y = Y+j, both delayed two stages alongside the data.
- FLUSH: 2 cycles to drain the pipeline. DONE: done pulse for 1 cycle, then return to IDLE (or CH_RUN if pending).
- Default 8x8 tile:
  - Last plot in cycle 66; done pulse in cycle 67.
  - A back-to-back BG+Char pair gives doneBG at cycle 67 and doneChar at cycle 135.
- Arithmetic: X+i is computed 9 bits wide and Y+j 8 bits wide. A pixel is clipped (vga_plot=0) if X+i >= SCREEN_W or Y+j >= SCREEN_H. No wrap-around.
- Clipped pixels still consume their cycle, so latency is fixed regardless of position. bg_addr is forced to 0 for clipped pixels.
- vga_plot=0 in IDLE, FLUSH-after-drain and DONE. vga_colour holds its last value when not plotting.

Optional Feature:
- Macro: SPRITE_TRANSPARENCY_EN.
- Defined: in CH_RUN, a sprite pixel equal to TRANSPARENT gets vga_plot=0, so the background shows through. Latency is unchanged.
- Undefined: every in-bounds sprite pixel is plotted, including TRANSPARENT-coloured ones.
- BG redraw is unaffected in both cases.

Decomposition:
- Shared package sprite_pkg holds:
  - state encoding localparams;
  - SCREEN_W/H defaults;
  - SPRITE_W/H defaults;
  - TRANSPARENT colour;
  - the bg address width (15).
- One natural sub-module: tile_scan_counter. It holds the i/j counters plus the last-pixel flag and is reused by both RUN states.

Test Plan:
- reset, then drawBG with xIn=1, yIn=16; bg ROM returns colour = addr[2:0].
  - 64 plots at (1..8, 16..23), colours matching; doneBG only at cycle 67; busy high cycles 1-67.
- drawChar at (40,30) with sprite ROM all 3'b010 -> 64 plots colour 3'b010; doneChar at cycle 67; doneBG never asserts.
- drawBG and drawChar in the same cycle at (10,10) -> doneBG at cycle 67, doneChar at cycle 135, no idle gap; a drawBG pulse injected at cycle 20 has no effect.
- drawChar at (156,116) -> only 16 plots (x 156-159, y 116-119); doneChar still at cycle 67.
- With SPRITE_TRANSPARENCY_EN, sprite ROM TRANSPARENT at even addresses -> 32 plots; without the macro -> 64 plots.
- reset asserted at cycle 30 of a BG frame -> vga_plot=0 from cycle 31; no doneBG; a fresh drawBG afterwards completes normally.
